pearson_hasher: RTL
===================

PEARSON_HASHER -- requirements
Module: pearson_hasher

Interface
REQ-001 Parameter INIT_HASH, default 8'h00: initial hash value loaded at the start of every message.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  in_data/in_last are valid.
REQ-005 in_ready  output  1  block accepts a byte this cycle.
REQ-006 in_data  input  8  message byte.
REQ-007 in_last  input  1  final byte of the message.
REQ-008 hash_valid  output  1  hash_out/msg_len are valid.
REQ-009 hash_ready  input  1  consumer accepts the result.
REQ-010 hash_out  output  HASH_W  final hash; HASH_W is 8, or 16 with PEARSON_HASH16_EN.
REQ-011 msg_len  output  16  byte count of the hashed message, saturating.

Function
REQ-012 The FSM SHALL have states IDLE, HASH and DONE.
- IDLE->HASH on an accepted non-last byte.
- IDLE/HASH->DONE on an accepted last byte.
- DONE->IDLE when hash_ready=1.
REQ-013 A byte SHALL be accepted when in_valid && in_ready; in_ready SHALL be 1 in IDLE and HASH and 0 in DONE.
REQ-014 On each accepted byte, running hash h SHALL update to T[h ^ in_data], where T is the 256-entry Pearson permutation.
- h = INIT_HASH for the first byte of a message.
- T is computed combinationally in the same cycle.
REQ-015 Throughput SHALL be one byte per cycle with no bubbles between bytes of a message.
REQ-016 hash_valid SHALL assert on the cycle after the last byte is accepted (latency 1).
- hash_out and msg_len SHALL be registered.
- Both SHALL be held stable while hash_valid=1 and hash_ready=0.
REQ-017 On the DONE->IDLE transition, h SHALL reload INIT_HASH and the byte counter SHALL clear.
- A new message SHALL be accepted from the next cycle; there is no overlap with DONE.
REQ-018 msg_len SHALL count accepted bytes including the last, saturating at 16'hFFFF.
REQ-019 Zero-length messages SHALL NOT be representable; every message has at least one byte, carrying in_last.
REQ-020 in_data and in_last SHALL be ignored when in_valid=0.
REQ-021 hash_ready SHALL be ignored outside DONE.

Reset
REQ-022 While rst_n=0 at a clock edge:
- State <= IDLE, h <= INIT_HASH, counter <= 0.
- hash_valid <= 0, hash_out <= 0, msg_len <= 0.
- in_ready SHALL read 1 from the first cycle after release.
REQ-023 Reset mid-message or in DONE SHALL discard all partial or pending results without emitting hash_valid.

Configuration
REQ-024 With macro PEARSON_HASH16_EN defined, HASH_W SHALL be 16 and two lanes SHALL run in parallel; hash_out = {lane1, lane0}.
- lane0 is as in REQ-014.
- lane1 uses (in_data + 1) mod 256 instead of in_data for the first byte only, and the identical update otherwise.
REQ-025 Without PEARSON_HASH16_EN, HASH_W SHALL be 8 and only lane0 exists.

Structure
REQ-026 Package pearson_pkg SHALL hold the FSM state enum, HASH_W selection and the MSG_LEN_W=16 constant.
REQ-027 The permutation SHALL be the existing lut module instantiated as a sub-module, once per lane.
- index = h ^ byte; lut_out is the next h.
- The table SHALL NOT be duplicated inside pearson_hasher.

Verification
REQ-028 Single byte 8'h00, last=1, INIT_HASH=0 -> next cycle hash_valid=1, hash_out=8'hFB, msg_len=1.
REQ-029 Bytes 8'h00, 8'h00 on consecutive cycles -> hash_out=8'h44, msg_len=2, in_ready held 1 across both bytes.
REQ-030 With hash_ready=0 for 3 cycles after single byte 8'h01 -> hash_out=8'hAF stable, in_ready=0 throughout; hash_ready=1 -> IDLE next cycle.
REQ-031 Byte 8'h05 accepted, rst_n=0 one cycle, then single byte 8'h00 -> hash_valid only once, hash_out=8'hFB, msg_len=1.
REQ-032 PEARSON_HASH16_EN defined, single byte 8'h00 -> hash_out=16'hAFFB.
REQ-033 70000-byte message of 8'h00 -> msg_len=16'hFFFF, hash_valid exactly once, one cycle after the last byte.

Source files
------------

// File: rtl/pearson_pkg.sv
// Shared types and constants for the Pearson hasher.
// Optional build macro: PEARSON_HASH16_EN selects the two-lane, 16-bit hash.
package pearson_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HASH = 2'd1,
    ST_DONE = 2'd2
  } state_t;

`ifdef PEARSON_HASH16_EN
  localparam int unsigned HASH_W    = 16;
`else
  localparam int unsigned HASH_W    = 8;
`endif

  localparam int unsigned MSG_LEN_W = 16;

endpackage

// File: rtl/pearson_hasher_if.sv
// Byte-stream input and hash-result output bundle for pearson_hasher.
// master drives bytes and accepts results; slave is the hasher.
interface pearson_hasher_if;
  import pearson_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 in_last;
  logic                 hash_valid;
  logic                 hash_ready;
  logic [HASH_W-1:0]    hash_out;
  logic [MSG_LEN_W-1:0] msg_len;

  modport master (
    output in_valid, in_data, in_last, hash_ready,
    input  in_ready, hash_valid, hash_out, msg_len
  );

  modport slave (
    input  in_valid, in_data, in_last, hash_ready,
    output in_ready, hash_valid, hash_out, msg_len
  );

endinterface

// File: rtl/pearson_hasher_lut.sv
// 256-entry Pearson permutation (RFC 3074 mixing table), purely combinational.
module lut (
  input  logic [7:0] i_index,
  output logic [7:0] o_value
);

  localparam logic [7:0] TABLE [256] = '{
    8'd251, 8'd175, 8'd119, 8'd215, 8'd81,  8'd14,  8'd79,  8'd191,
    8'd103, 8'd49,  8'd181, 8'd143, 8'd186, 8'd157, 8'd0,   8'd232,
    8'd31,  8'd32,  8'd55,  8'd60,  8'd152, 8'd58,  8'd17,  8'd237,
    8'd174, 8'd70,  8'd160, 8'd144, 8'd220, 8'd90,  8'd57,  8'd223,
    8'd59,  8'd3,   8'd18,  8'd140, 8'd111, 8'd166, 8'd203, 8'd196,
    8'd134, 8'd243, 8'd124, 8'd95,  8'd222, 8'd179, 8'd197, 8'd65,
    8'd180, 8'd48,  8'd36,  8'd15,  8'd107, 8'd46,  8'd233, 8'd130,
    8'd165, 8'd30,  8'd123, 8'd161, 8'd209, 8'd23,  8'd97,  8'd16,
    8'd40,  8'd91,  8'd219, 8'd61,  8'd100, 8'd10,  8'd210, 8'd109,
    8'd250, 8'd127, 8'd22,  8'd138, 8'd29,  8'd108, 8'd244, 8'd67,
    8'd207, 8'd9,   8'd178, 8'd204, 8'd74,  8'd98,  8'd126, 8'd249,
    8'd167, 8'd116, 8'd34,  8'd77,  8'd193, 8'd200, 8'd121, 8'd5,
    8'd20,  8'd113, 8'd71,  8'd35,  8'd128, 8'd13,  8'd182, 8'd94,
    8'd25,  8'd226, 8'd227, 8'd199, 8'd75,  8'd27,  8'd41,  8'd245,
    8'd230, 8'd224, 8'd43,  8'd225, 8'd177, 8'd26,  8'd155, 8'd150,
    8'd212, 8'd142, 8'd218, 8'd115, 8'd241, 8'd73,  8'd88,  8'd105,
    8'd39,  8'd114, 8'd62,  8'd255, 8'd192, 8'd201, 8'd145, 8'd214,
    8'd168, 8'd158, 8'd221, 8'd148, 8'd154, 8'd122, 8'd12,  8'd84,
    8'd82,  8'd163, 8'd44,  8'd139, 8'd228, 8'd236, 8'd205, 8'd242,
    8'd217, 8'd11,  8'd187, 8'd146, 8'd159, 8'd64,  8'd86,  8'd239,
    8'd195, 8'd42,  8'd106, 8'd198, 8'd118, 8'd112, 8'd184, 8'd172,
    8'd87,  8'd2,   8'd173, 8'd117, 8'd176, 8'd229, 8'd247, 8'd253,
    8'd137, 8'd185, 8'd99,  8'd164, 8'd102, 8'd147, 8'd45,  8'd66,
    8'd231, 8'd52,  8'd141, 8'd211, 8'd194, 8'd206, 8'd246, 8'd238,
    8'd56,  8'd110, 8'd78,  8'd248, 8'd63,  8'd240, 8'd189, 8'd93,
    8'd92,  8'd51,  8'd53,  8'd183, 8'd19,  8'd171, 8'd72,  8'd50,
    8'd33,  8'd104, 8'd101, 8'd69,  8'd8,   8'd252, 8'd83,  8'd120,
    8'd76,  8'd135, 8'd85,  8'd54,  8'd202, 8'd125, 8'd188, 8'd213,
    8'd96,  8'd235, 8'd136, 8'd208, 8'd162, 8'd129, 8'd190, 8'd132,
    8'd156, 8'd38,  8'd47,  8'd1,   8'd7,   8'd254, 8'd24,  8'd4,
    8'd216, 8'd131, 8'd89,  8'd21,  8'd28,  8'd133, 8'd37,  8'd153,
    8'd149, 8'd80,  8'd170, 8'd68,  8'd6,   8'd169, 8'd234, 8'd151
  };

  assign o_value = TABLE[i_index];

endmodule

// File: rtl/pearson_hasher.sv
// Streaming Pearson hasher: one byte per cycle, result one cycle after the
// last byte, held until the consumer accepts it.
// Optional build macro: PEARSON_HASH16_EN adds a second lane (16-bit hash).
module pearson_hasher
  import pearson_pkg::*;
#(
  parameter logic [7:0] INIT_HASH = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  pearson_hasher_if.slave bus
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_accept;
  logic                 w_release;
  logic [7:0]           r_h0;
  logic [7:0]           w_t0;
  logic [MSG_LEN_W-1:0] r_cnt;
  logic [MSG_LEN_W-1:0] w_cnt_next;
  logic [HASH_W-1:0]    w_hash_next;
  logic [HASH_W-1:0]    r_hash_out;
  logic [MSG_LEN_W-1:0] r_msg_len;

  assign bus.in_ready   = (r_state != ST_DONE);
  assign bus.hash_valid = (r_state == ST_DONE);
  assign bus.hash_out   = r_hash_out;
  assign bus.msg_len    = r_msg_len;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_release  = (r_state == ST_DONE) && bus.hash_ready;
  assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  lut u_lut0 (
    .i_index (r_h0 ^ bus.in_data),
    .o_value (w_t0)
  );

`ifdef PEARSON_HASH16_EN
  logic [7:0] r_h1;
  logic [7:0] w_t1;
  logic [7:0] w_byte1;

  // In IDLE the lanes still hold INIT_HASH, so IDLE marks the first byte.
  assign w_byte1 = (r_state == ST_IDLE) ? bus.in_data + 8'd1 : bus.in_data;

  lut u_lut1 (
    .i_index (r_h1 ^ w_byte1),
    .o_value (w_t1)
  );

  assign w_hash_next = {w_t1, w_t0};

  // Lane 1 running hash: reload on result hand-off, advance per accepted byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h1 <= INIT_HASH;
    end else if (w_release) begin
      r_h1 <= INIT_HASH;
    end else if (w_accept) begin
      r_h1 <= w_t1;
    end
  end
`else
  assign w_hash_next = w_t0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = bus.in_last ? ST_DONE : ST_HASH;
        end
      end
      ST_HASH: begin
        if (w_accept && bus.in_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.hash_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Lane 0 running hash and saturating byte counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h0  <= INIT_HASH;
      r_cnt <= '0;
    end else if (w_release) begin
      r_h0  <= INIT_HASH;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_h0  <= w_t0;
      r_cnt <= w_cnt_next;
    end
  end

  // Result registers: captured with the last byte, held through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hash_out <= '0;
      r_msg_len  <= '0;
    end else if (w_accept && bus.in_last) begin
      r_hash_out <= w_hash_next;
      r_msg_len  <= w_cnt_next;
    end
  end

endmodule
